// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits directly behind the PC register. It latches the current
// PC, issues exactly one instruction-memory read for it over a req/gnt/rvalid
// interface and presents the returned word to decode over valid/ready. The PC
// register is told to advance (pc_hold=0) only in the cycle decode accepts an
// instruction, or in a flush cycle so it can load the branch target.
//
// A flush abandons the fetch in progress. If a read was already granted, its
// response is still on its way, so it is marked for discard (drop_pending) and
// no new read is issued until it arrives or the timeout window expires.
// Misaligned PCs and reads that never return are delivered as faults carrying
// NOP_WORD.
//
// Parameters
//   TIMEOUT_CYCLES  cycles to wait for rvalid before a timeout fault (>=2)
//   NOP_WORD        instruction word delivered together with a fault
//
// Ports
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   pc_in        in   32  current PC from the PC register
//   pc_hold      out  1   1 = PC register must not advance this cycle
//   flush        in   1   taken branch/jump; abandon current fetch
//   imem_req     out  1   read request, held until imem_gnt
//   imem_addr    out  32  read address (latched PC)
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid, earliest one cycle after gnt
//   imem_rdata   in   32  read data
//   inst_valid   out  1   instruction available to decode
//   inst_ready   in   1   decode accepts the instruction
//   inst         out  32  instruction word
//   inst_pc      out  32  PC the instruction was fetched from
//   fetch_fault  out  1   1 = misaligned PC or timeout; inst = NOP_WORD
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_hold,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  // The counter only has to reach TIMEOUT_CYCLES-1: the cycle in which it sits
  // there is the TIMEOUT_CYCLES-th cycle of waiting.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,  // latch PC, decide between request and misalignment fault
    S_REQ,   // request held until granted
    S_WAIT,  // granted, waiting for read data
    S_HOLD   // instruction presented to decode
  } state_t;

  state_t         state;
  logic           drop_pending;  // a granted read was abandoned; its data must be discarded
  logic [CNT_W-1:0] wait_cnt;    // cycles spent waiting for rvalid (read or discarded read)

  logic cnt_hit;    // this is the last cycle of the timeout window
  logic drop_done;  // the abandoned read resolves this cycle (data seen or window over)
  logic fetch_ok;   // IDLE may latch a new PC this cycle
  logic deliver;    // decode takes the presented instruction this cycle

  assign cnt_hit   = (wait_cnt == CNT_LAST);
  assign drop_done = drop_pending && (imem_rvalid || cnt_hit);
  // A stale rvalid in the same cycle clears the discard, so IDLE need not wait
  // for one extra cycle before latching the next PC.
  assign fetch_ok  = !drop_pending || imem_rvalid;
  assign deliver   = (state == S_HOLD) && inst_valid && inst_ready && !flush;

  // pc_hold is the only combinational output: the PC register must see the
  // handshake (and the flush) in the same cycle to advance exactly once.
  assign pc_hold = reset || !(deliver || flush);

  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values of one another; a blocking assignment would let later
  // statements see already-updated state and break the FSM ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      imem_req     <= 1'b0;
      imem_addr    <= 32'h0;
      inst_valid   <= 1'b0;
      inst         <= 32'h0;
      inst_pc      <= 32'h0;
      fetch_fault  <= 1'b0;
      drop_pending <= 1'b0;
      wait_cnt     <= '0;
    end else if (flush) begin
      // Flush overrides whatever the current state would have done.
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
      // A read is still in flight if it was granted and its data has not come
      // back yet, either from WAIT or from a grant arriving right now in REQ.
      // An older discard carries over unless it resolves this very cycle.
      drop_pending <= ((state == S_WAIT) && !imem_rvalid)
                   || ((state == S_REQ) && imem_gnt)
                   || (drop_pending && !drop_done);
    end else begin
      // Background timer for an abandoned read; runs in whatever state the
      // FSM is in. WAIT is never reached with drop_pending set, so the state
      // logic below never competes for wait_cnt while this is active.
      if (drop_pending) begin
        if (drop_done) begin
          drop_pending <= 1'b0;
          wait_cnt     <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (fetch_ok) begin
            imem_addr <= pc_in;
            if (pc_in[1:0] != 2'b00) begin
              // Misaligned: no memory access, deliver a fault straight away.
              state       <= S_HOLD;
              inst_valid  <= 1'b1;
              inst        <= NOP_WORD;
              inst_pc     <= pc_in;
              fetch_fault <= 1'b1;
            end else begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (imem_gnt) begin
            state    <= S_WAIT;
            imem_req <= 1'b0;
            wait_cnt <= '0;
          end
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            state       <= S_HOLD;
            inst_valid  <= 1'b1;
            inst        <= imem_rdata;
            inst_pc     <= imem_addr;
            fetch_fault <= 1'b0;
          end else if (cnt_hit) begin
            // The read may still answer later; discard it when it does.
            state        <= S_HOLD;
            inst_valid   <= 1'b1;
            inst         <= NOP_WORD;
            inst_pc      <= imem_addr;
            fetch_fault  <= 1'b1;
            drop_pending <= 1'b1;
            wait_cnt     <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          // inst/inst_pc/fetch_fault are simply not written here, so they
          // stay stable under backpressure.
          if (inst_ready) begin
            state      <= S_IDLE;
            inst_valid <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run
// with a memory responder, a PC-register model and a transaction scoreboard.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_hold;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  instr_fetch_unit #(
    .TIMEOUT_CYCLES(TO),
    .NOP_WORD      (NOP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_hold    (pc_hold),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 time units
  // after the rising edge.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".imem_req"},    imem_req,    1'b0);
    check({tag, ".imem_addr"},   imem_addr,   32'h0);
    check({tag, ".inst_valid"},  inst_valid,  1'b0);
    check({tag, ".inst"},        inst,        32'h0);
    check({tag, ".inst_pc"},     inst_pc,     32'h0);
    check({tag, ".fetch_fault"}, fetch_fault, 1'b0);
    check({tag, ".pc_hold"},     pc_hold,     1'b1);
  endtask

  // Instruction memory contents for the random phase.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h5A5A_3C3C;
  endfunction

  // Random-phase environment state.
  logic        outstanding;
  int          rsp_delay;
  logic [31:0] rsp_addr;
  logic [31:0] pc_next;
  logic [31:0] flush_target;
  logic [31:0] exp_inst;
  int          deliveries;

  initial begin
    reset       = 1'b1;
    pc_in       = 32'h0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b0;

    // ---------------- reset values ----------------
    repeat (2) cyc();
    check_reset("reset");
    reset = 1'b0;

    // ---------------- T1: basic fetch at PC 0 ----------------
    cyc();                                   // IDLE -> REQ
    check("t1.req", imem_req, 1'b1);
    check("t1.addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    #1 check("t1.pc_hold_req", pc_hold, 1'b1);
    cyc();                                   // REQ -> WAIT
    imem_gnt = 1'b0;
    check("t1.req_dropped", imem_req, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2008_0005;
    cyc();                                   // WAIT -> HOLD
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0BAD_0BAD;
    check("t1.valid", inst_valid, 1'b1);
    check("t1.inst", inst, 32'h2008_0005);
    check("t1.inst_pc", inst_pc, 32'h0);
    check("t1.fault", fetch_fault, 1'b0);
    inst_ready = 1'b1;
    #1 check("t1.pc_hold_accept", pc_hold, 1'b0);
    cyc();                                   // HOLD -> IDLE
    inst_ready = 1'b0;
    pc_in      = 32'h4;
    check("t1.valid_cleared", inst_valid, 1'b0);
    #1 check("t1.pc_hold_after", pc_hold, 1'b1);

    // ---------------- T2: backpressure ----------------
    cyc();
    check("t2.req", imem_req, 1'b1);
    check("t2.addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_2222;
    cyc();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2.valid", inst_valid, 1'b1);
      check("t2.inst", inst, 32'h1111_2222);
      check("t2.inst_pc", inst_pc, 32'h4);
      check("t2.no_req", imem_req, 1'b0);
      #1 check("t2.pc_hold", pc_hold, 1'b1);
      cyc();
    end
    check("t2.still_valid", inst_valid, 1'b1);
    inst_ready = 1'b1;
    #1 check("t2.pc_hold_accept", pc_hold, 1'b0);
    cyc();
    inst_ready = 1'b0;
    pc_in      = 32'h8;
    check("t2.valid_cleared", inst_valid, 1'b0);

    // ---------------- T3: flush in WAIT, stale data discarded ----------------
    cyc();
    check("t3.req", imem_req, 1'b1);
    imem_gnt = 1'b1;
    cyc();                                   // -> WAIT
    imem_gnt = 1'b0;
    flush    = 1'b1;
    #1 check("t3.pc_hold_flush", pc_hold, 1'b0);
    cyc();                                   // -> IDLE, read marked for discard
    flush = 1'b0;
    pc_in = 32'h40;
    check("t3.valid_after_flush", inst_valid, 1'b0);
    check("t3.req_after_flush", imem_req, 1'b0);
    cyc();
    check("t3.idle_blocked", imem_req, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cyc();                                   // stale data dropped, PC 0x40 latched
    imem_rvalid = 1'b0;
    check("t3.stale_not_valid", inst_valid, 1'b0);
    check("t3.req_new", imem_req, 1'b1);
    check("t3.addr_new", imem_addr, 32'h40);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0020;
    cyc();
    imem_rvalid = 1'b0;
    check("t3.valid", inst_valid, 1'b1);
    check("t3.inst", inst, 32'h0000_0020);
    check("t3.inst_pc", inst_pc, 32'h40);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    pc_in      = 32'h6;

    // ---------------- T4: misaligned PC ----------------
    cyc();
    check("t4.no_req", imem_req, 1'b0);
    check("t4.valid", inst_valid, 1'b1);
    check("t4.fault", fetch_fault, 1'b1);
    check("t4.inst", inst, NOP);
    check("t4.inst_pc", inst_pc, 32'h6);
    inst_ready = 1'b1;
    #1 check("t4.pc_hold_accept", pc_hold, 1'b0);
    cyc();
    inst_ready = 1'b0;
    pc_in      = 32'h80;
    check("t4.valid_cleared", inst_valid, 1'b0);

    // ---------------- T5: timeout ----------------
    cyc();
    check("t5.req", imem_req, 1'b1);
    imem_gnt = 1'b1;
    cyc();                                   // WAIT entry edge
    imem_gnt = 1'b0;
    for (int i = 1; i < int'(TO); i++) begin
      cyc();
      check("t5.not_yet", inst_valid, 1'b0);
    end
    cyc();                                   // TO cycles after WAIT entry
    check("t5.valid", inst_valid, 1'b1);
    check("t5.fault", fetch_fault, 1'b1);
    check("t5.inst", inst, NOP);
    check("t5.inst_pc", inst_pc, 32'h80);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    pc_in      = 32'h84;
    cyc();
    check("t5.idle_blocked", imem_req, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAAD_F00D;
    cyc();                                   // late data dropped, PC 0x84 latched
    imem_rvalid = 1'b0;
    check("t5.late_not_valid", inst_valid, 1'b0);
    check("t5.req_new", imem_req, 1'b1);
    check("t5.addr_new", imem_addr, 32'h84);
    imem_gnt = 1'b1;
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_0001;
    cyc();
    imem_rvalid = 1'b0;
    check("t5.next_inst", inst, 32'hCAFE_0001);
    check("t5.next_pc", inst_pc, 32'h84);
    check("t5.next_fault", fetch_fault, 1'b0);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    pc_in      = 32'h100;

    // ---------------- T6: asynchronous reset in WAIT ----------------
    cyc();
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    cyc();                                   // waiting for data
    check("t6.in_wait", imem_req, 1'b0);
    reset = 1'b1;
    #1 check_reset("t6");
    cyc();
    reset = 1'b0;

    // ---------------- random phase ----------------
    outstanding = 1'b0;
    rsp_delay   = 0;
    rsp_addr    = 32'h0;
    pc_next     = 32'h100;
    deliveries  = 0;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      pc_in = pc_next;

      // Memory: grants at random, answers 1..3 cycles after the grant,
      // regardless of any flush in between.
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (outstanding) begin
        rsp_delay--;
        if (rsp_delay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(rsp_addr);
          outstanding = 1'b0;
        end
      end else if (imem_req && ($urandom_range(0, 2) != 0)) begin
        imem_gnt    = 1'b1;
        outstanding = 1'b1;
        rsp_addr    = imem_addr;
        rsp_delay   = int'($urandom_range(1, 3));
      end

      flush        = ($urandom_range(0, 15) == 0);
      flush_target = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 9) == 0) flush_target = flush_target | 32'h2;
      inst_ready   = ($urandom_range(0, 3) != 0);
      #1;

      check("rnd.pc_hold", pc_hold, !(flush || (inst_valid && inst_ready)));
      if (imem_req) check("rnd.addr", imem_addr, pc_in);
      if (inst_valid && inst_ready && !flush) begin
        deliveries++;
        exp_inst = (pc_in[1:0] != 2'b00) ? NOP : mem_word(pc_in);
        check("rnd.inst_pc", inst_pc, pc_in);
        check("rnd.inst", inst, exp_inst);
        check("rnd.fault", fetch_fault, pc_in[1:0] != 2'b00);
      end

      // PC register: holds unless released; loads the target on flush.
      if (pc_hold) pc_next = pc_in;
      else if (flush) pc_next = flush_target;
      else pc_next = pc_in + 32'h4;
    end
    flush      = 1'b0;
    inst_ready = 1'b0;
    check("rnd.progress", deliveries >= 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
